// File: rtl/int_decoder.sv
// Interrupter link receiver: resynchronise and glitch-filter the optical pulse train,
// measure width/period, and re-drive a safety-gated copy to the bridge drive.
module int_decoder #(
    parameter int CLK_MHZ     = 100,
    parameter int FREQ_MIN_HZ = 10_000,
    parameter int PW_MAX_US   = 50,
    parameter int FILT_CYCLES = 4,
    localparam int PERIOD_MAX = CLK_MHZ * 1_000_000 / FREQ_MIN_HZ,
    localparam int PW_MAX     = PW_MAX_US * CLK_MHZ,
    localparam int W          = $clog2(PERIOD_MAX + 1)
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         int_in,
    output logic         out,
    output logic [W-1:0] pw_cycles,
    output logic [W-1:0] period_cycles,
    output logic         meas_valid,
    output logic         pw_trunc,
    output logic         signal_lost
);

    localparam int FW = $clog2(FILT_CYCLES + 1);
    localparam logic [FW-1:0] FILT_LAST = FW'(FILT_CYCLES - 1);
    localparam logic [W-1:0]  PMAX      = W'(PERIOD_MAX);
    localparam logic [W-1:0]  PWMAX     = W'(PW_MAX);

    typedef enum logic [2:0] {LOST, HIGH_FIRST, HIGH, LOW_FIRST, LOW} state_t;

    logic          sync_p0, sync_p1;
    logic          filt_p2, filt_p3;
    logic [FW-1:0] filt_cnt;
    logic [W-1:0]  cnt;
    logic          rise, fall;
    state_t        state;

    function automatic logic [W-1:0] sat_inc(input logic [W-1:0] v);
        return (v >= PMAX) ? PMAX : v + W'(1);
    endfunction

    // Stages p0/p1: two-flop synchroniser; p2: filtered level; p3: delayed level for edge detect
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sync_p0  <= 1'b0;
            sync_p1  <= 1'b0;
            filt_p2  <= 1'b0;
            filt_p3  <= 1'b0;
            filt_cnt <= '0;
        end else begin
            sync_p0 <= int_in;
            sync_p1 <= sync_p0;
            filt_p3 <= filt_p2;
            if (sync_p1 == filt_p2) begin
                filt_cnt <= '0;
            end else if (filt_cnt == FILT_LAST) begin
                filt_p2  <= sync_p1;
                filt_cnt <= '0;
            end else begin
                filt_cnt <= filt_cnt + FW'(1);
            end
        end
    end

    assign rise = filt_p2 & ~filt_p3;
    assign fall = ~filt_p2 & filt_p3;

    // Measurement and gating stage: edges take priority over timeout and truncation
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state         <= LOST;
            cnt           <= '0;
            out           <= 1'b0;
            pw_cycles     <= '0;
            period_cycles <= '0;
            meas_valid    <= 1'b0;
            pw_trunc      <= 1'b0;
            signal_lost   <= 1'b1;
        end else begin
            meas_valid <= 1'b0;
            cnt        <= rise ? W'(1) : sat_inc(cnt);
            case (state)
                LOST: begin
                    out <= 1'b0;
                    if (rise) begin
                        state    <= HIGH_FIRST;
                        pw_trunc <= 1'b0;
                        out      <= 1'b1;
                    end
                end
                HIGH_FIRST, HIGH: begin
                    if (fall) begin
                        pw_cycles <= cnt;
                        state     <= (state == HIGH) ? LOW : LOW_FIRST;
                        out       <= 1'b0;
                    end else if (cnt >= PMAX) begin
                        state       <= LOST;
                        out         <= 1'b0;
                        signal_lost <= 1'b1;
                    end else if (cnt >= PWMAX) begin
                        pw_trunc <= 1'b1;
                        out      <= 1'b0;
                    end
                end
                LOW_FIRST, LOW: begin
                    if (rise) begin
                        period_cycles <= cnt;
                        meas_valid    <= (state == LOW);
                        state         <= HIGH;
                        pw_trunc      <= 1'b0;
                        signal_lost   <= 1'b0;
                        out           <= 1'b1;
                    end else if (cnt >= PMAX) begin
                        state       <= LOST;
                        signal_lost <= 1'b1;
                    end
                end
                default: begin
                    state <= LOST;
                    out   <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_int_decoder.sv
// Bench for int_decoder: directed test-plan steps plus a random pulse train, every cycle
// compared against a timestamp-based reference model of the receiver.
module tb_int_decoder;

    localparam int PERIOD_MAX = 10000;
    localparam int PW_MAX     = 5000;
    localparam int FILT       = 4;
    localparam int W          = $clog2(PERIOD_MAX + 1);

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         int_in = 1'b0;
    logic         out;
    logic [W-1:0] pw_cycles;
    logic [W-1:0] period_cycles;
    logic         meas_valid;
    logic         pw_trunc;
    logic         signal_lost;

    int_decoder dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .int_in       (int_in),
        .out          (out),
        .pw_cycles    (pw_cycles),
        .period_cycles(period_cycles),
        .meas_valid   (meas_valid),
        .pw_trunc     (pw_trunc),
        .signal_lost  (signal_lost)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // reference model: link mode, timestamps instead of a counter
    typedef enum {M_LOST, M_HF, M_H, M_LF, M_L} mode_t;
    mode_t m_mode = M_LOST;
    int    edge_no = 0;
    int    m_anchor = 0;
    int    m_pend = 0;             // 0 none, 1 rise, 2 fall (acted on next edge)
    bit    m_a = 0, m_b = 0, m_f = 0;
    bit    win[$];
    int    e_out = 0, e_pw = 0, e_per = 0, e_mv = 0, e_trunc = 0, e_lost = 1;

    // observation bookkeeping for directed checks
    int mv_cnt = 0, mv_pw = 0, mv_per = 0, hi_cnt = 0, trunc_seen = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
        end
    endtask

    function automatic void model_step(input bit in_s, input bit rst_s);
        bit filt_in, flip;
        int c, ev;
        if (!rst_s) begin
            m_a = 0; m_b = 0; m_f = 0; m_pend = 0; win.delete();
            m_mode = M_LOST; m_anchor = edge_no + 1;
            e_out = 0; e_pw = 0; e_per = 0; e_mv = 0; e_trunc = 0; e_lost = 1;
            return;
        end
        filt_in = m_b; m_b = m_a; m_a = in_s;
        ev = m_pend;
        c = edge_no - m_anchor;
        if (c > PERIOD_MAX) c = PERIOD_MAX;
        e_mv = 0;
        case (m_mode)
            M_LOST: if (ev == 1) begin m_mode = M_HF; e_trunc = 0; end
            M_HF, M_H: begin
                if (ev == 2) begin e_pw = c; m_mode = (m_mode == M_H) ? M_L : M_LF; end
                else if (c == PERIOD_MAX) begin m_mode = M_LOST; e_lost = 1; end
                else if (c >= PW_MAX) e_trunc = 1;
            end
            M_LF, M_L: begin
                if (ev == 1) begin
                    e_per = c; e_mv = (m_mode == M_L); m_mode = M_H; e_trunc = 0; e_lost = 0;
                end else if (c == PERIOD_MAX) begin m_mode = M_LOST; e_lost = 1; end
            end
            default: m_mode = M_LOST;
        endcase
        if (ev == 1) m_anchor = edge_no;
        e_out = ((m_mode == M_HF || m_mode == M_H) && !e_trunc) ? 1 : 0;
        // level accepted once the last FILT synced samples all disagree with it
        win.push_back(filt_in);
        if (win.size() > FILT) void'(win.pop_front());
        flip = (win.size() == FILT);
        foreach (win[i]) if (win[i] == m_f) flip = 0;
        m_pend = 0;
        if (flip) begin
            m_f = !m_f;
            m_pend = m_f ? 1 : 2;
            win.delete();
        end
    endfunction

    task automatic tick();
        @(posedge clk);
        edge_no++;
        model_step(int_in, rst_n);
        #1;
        check("out", out, e_out);
        check("pw_cycles", pw_cycles, e_pw);
        check("period_cycles", period_cycles, e_per);
        check("meas_valid", meas_valid, e_mv);
        check("pw_trunc", pw_trunc, e_trunc);
        check("signal_lost", signal_lost, e_lost);
        if (meas_valid === 1'b1) begin mv_cnt++; mv_pw = pw_cycles; mv_per = period_cycles; end
        if (out === 1'b1) hi_cnt++;
        if (pw_trunc === 1'b1) trunc_seen = 1;
    endtask

    task automatic run(input bit lvl, input int n);
        int_in = lvl;
        repeat (n) tick();
    endtask

    initial begin
        int n;
        // reset held while the input toggles
        rst_n = 0;
        for (int i = 0; i < 5; i++) begin int_in = ~int_in; tick(); end
        check("rst_signal_lost", signal_lost, 1);
        check("rst_out", out, 0);
        check("rst_period", period_cycles, 0);
        rst_n = 1;

        // glitch rejection on a steady-low line
        run(0, 50);
        hi_cnt = 0; run(1, 3); run(0, 40);
        check("glitch3_out_cycles", hi_cnt, 0);
        hi_cnt = 0; run(1, 4); run(0, 40);
        check("pulse4_out_cycles", hi_cnt, 4);
        rst_n = 0; tick(); tick(); rst_n = 1;

        // 1000/3000 square wave
        mv_cnt = 0;
        run(1, 1000); run(0, 3000);
        check("sq_lost_after_p1", signal_lost, 1);
        run(1, 1000); run(0, 3000);
        check("sq_no_strobe_p2", mv_cnt, 0);
        check("sq_lost_cleared", signal_lost, 0);
        run(1, 1000); run(0, 3000);
        run(1, 1000); run(0, 3000);
        check("sq_strobes", mv_cnt, 2);
        check("sq_pw", mv_pw, 1000);
        check("sq_period", mv_per, 4000);

        // over-long pulse truncation
        hi_cnt = 0; trunc_seen = 0;
        run(1, 6000);
        check("long_trunc_flag", pw_trunc, 1);
        run(0, 3000);
        check("long_out_cycles", hi_cnt, PW_MAX);
        check("long_trunc_seen", trunc_seen, 1);
        mv_cnt = 0;
        run(1, 1000);
        check("long_strobe", mv_cnt, 1);
        check("long_pw", mv_pw, 6000);
        check("long_period", mv_per, 9000);
        check("long_trunc_clear", pw_trunc, 0);
        run(0, 3000);

        // loss of signal
        run(1, 1000); run(0, 3000);
        run(0, 11000);
        check("los_lost", signal_lost, 1);
        check("los_out", out, 0);
        mv_cnt = 0;
        run(1, 1000); run(0, 3000);
        run(1, 1000); run(0, 3000);
        check("los_no_strobe", mv_cnt, 0);

        // reset in the middle of a high pulse
        run(1, 506);
        rst_n = 0; tick();
        check("midrst_out", out, 0);
        tick(); tick();
        rst_n = 1;
        n = 0;
        while (out !== 1'b1 && n < 50) begin tick(); n++; end
        check("midrst_latency", n, FILT + 3);
        mv_cnt = 0;
        run(1, 1000); run(0, 3000);
        run(1, 1000); run(0, 3000);
        check("midrst_no_strobe", mv_cnt, 0);
        run(1, 20);
        check("midrst_strobe", mv_cnt, 1);
        run(1, 980); run(0, 3000);

        // random pulse train including sub-filter glitches
        for (int p = 0; p < 40; p++) begin
            run(1, ($urandom_range(0, 3) == 0) ? $urandom_range(1, 6) : $urandom_range(8, 400));
            run(0, ($urandom_range(0, 3) == 0) ? $urandom_range(1, 6) : $urandom_range(8, 400));
        end
        run(0, 20);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
